line_buf_pingpong_ctrl: RTL and testbench

- Sequences one line_buf SDP RAM (2^(COL_WIDTH+1) x DATA_WIDTH, unregistered output, 1-cycle read latency) as a ping-pong pair of line banks.
- Writes the incoming pixel line into one bank while reading the previous line from the other bank at the same column.
- Emits a 2-row column stream: current pixel plus the pixel directly above it. Feeds the vertical stages of the video filter / target-detect pipeline.

---
 rtl/line_buf_pingpong_ctrl_if.sv | 48 ++++
 rtl/line_buf_pingpong_ctrl.sv | 134 +++++++++++++
 tb/tb_line_buf_pingpong_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_pingpong_ctrl_if.sv
// line_buf_pingpong_ctrl_if: video in, line_buf RAM ports, 2-row column out.
// Modports: master = controller side, slave = source/RAM/sink side.
interface line_buf_pingpong_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_WIDTH  = 10
) ();
  logic                  in_vs;
  logic                  in_de;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [COL_WIDTH:0]    ram_wr_addr;
  logic                  ram_wr_en;
  logic [COL_WIDTH:0]    ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  out_de;
  logic [DATA_WIDTH-1:0] out_cur;
  logic [DATA_WIDTH-1:0] out_prev;
  logic                  out_prev_vld;
  logic                  ovf;
`ifdef LINE_BUF_PINGPONG_CTRL_STATS_EN
  logic [COL_WIDTH:0]    line_len;
  logic [15:0]           line_cnt;
`endif

  modport master (
    input  in_vs, in_de, in_data,
    input  ram_rd_data,
    output ram_wr_data, ram_wr_addr,
    output ram_wr_en, ram_rd_addr,
    output out_de, out_cur, out_prev,
    output out_prev_vld, ovf
`ifdef LINE_BUF_PINGPONG_CTRL_STATS_EN
    , output line_len, line_cnt
`endif
  );

  modport slave (
    output in_vs, in_de, in_data,
    output ram_rd_data,
    input  ram_wr_data, ram_wr_addr,
    input  ram_wr_en, ram_rd_addr,
    input  out_de, out_cur, out_prev,
    input  out_prev_vld, ovf
`ifdef LINE_BUF_PINGPONG_CTRL_STATS_EN
    , input line_len, line_cnt
`endif
  );
endinterface

// File: rtl/line_buf_pingpong_ctrl.sv
// line_buf_pingpong_ctrl: ping-pong line banks in one SDP RAM, 2-row output.
// Ports: clk, rstn (sync, active-low), bus (master). Option: LINE_BUF_PINGPONG_CTRL_STATS_EN.
module line_buf_pingpong_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_WIDTH  = 10
) (
  input logic                      clk,
  input logic                      rstn,
  line_buf_pingpong_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, ARMED, ACTIVE, BLANK
  } state_t;

  state_t state_q, state_d;

  logic                  vs_q;
  logic                  de_q;
  logic                  blk_q;
  logic [COL_WIDTH:0]    col_q;
  logic [COL_WIDTH:0]    prev_len_q;
  logic                  wbank_q;
  logic                  first_q;
  logic                  ovf_q;
  logic                  out_de_q;
  logic [DATA_WIDTH-1:0] out_cur_q;
  logic                  pv_q;

  logic vs_rise;
  logic de_eff;
  logic act;
  logic de_fall;
  logic wr_ok;
  logic pv_d;

  assign vs_rise = bus.in_vs & ~vs_q;
  // de stays masked after a vs rise until it has been seen low
  assign de_eff  = bus.in_de & ~blk_q & ~vs_rise;
  assign act     = rstn & de_eff & (state_q != IDLE);
  assign de_fall = de_q & ~act;
  // col MSB set means the line has run past the bank
  assign wr_ok   = act & ~col_q[COL_WIDTH];
  assign pv_d    = act & ~first_q
                 & (col_q < prev_len_q);

  assign bus.ram_wr_en   = wr_ok;
  assign bus.ram_wr_data = wr_ok ? bus.in_data : '0;
  assign bus.ram_wr_addr = wr_ok ?
    {wbank_q, col_q[COL_WIDTH-1:0]} : '0;
  assign bus.ram_rd_addr = wr_ok ?
    {~wbank_q, col_q[COL_WIDTH-1:0]} : '0;

  // RAM data arrives one cycle after its address
  assign bus.out_de       = out_de_q;
  assign bus.out_cur      = out_cur_q;
  assign bus.out_prev_vld = pv_q;
  assign bus.out_prev     = pv_q ? bus.ram_rd_data : '0;
  assign bus.ovf          = ovf_q;

  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:   state_d = IDLE;
        ARMED:  if (de_eff) state_d = ACTIVE;
        ACTIVE: if (de_fall) state_d = BLANK;
        BLANK:  if (de_eff) state_d = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      blk_q      <= 1'b0;
      col_q      <= '0;
      prev_len_q <= '0;
      wbank_q    <= 1'b0;
      first_q    <= 1'b1;
      ovf_q      <= 1'b0;
      out_de_q   <= 1'b0;
      out_cur_q  <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= bus.in_vs;
      de_q      <= act;
      out_de_q  <= act;
      out_cur_q <= act ? bus.in_data : '0;
      pv_q      <= pv_d;
      if (vs_rise)
        blk_q <= 1'b1;
      else if (!bus.in_de)
        blk_q <= 1'b0;
      // vs wins: an unfinished line is dropped
      if (vs_rise) begin
        col_q   <= '0;
        wbank_q <= 1'b0;
        first_q <= 1'b1;
        ovf_q   <= 1'b0;
      end else if (de_fall) begin
        prev_len_q <= col_q;
        wbank_q    <= ~wbank_q;
        col_q      <= '0;
        first_q    <= 1'b0;
      end else if (act) begin
        if (col_q[COL_WIDTH])
          ovf_q <= 1'b1;
        else
          col_q <= col_q + 1'b1;
      end
    end
  end

`ifdef LINE_BUF_PINGPONG_CTRL_STATS_EN
  logic [15:0] line_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      line_cnt_q <= '0;
    else if (vs_rise)
      line_cnt_q <= '0;
    else if (de_fall && line_cnt_q != 16'hFFFF)
      line_cnt_q <= line_cnt_q + 16'd1;
  end

  assign bus.line_len = prev_len_q;
  assign bus.line_cnt = line_cnt_q;
`endif
endmodule

// File: tb/tb_line_buf_pingpong_ctrl.sv
// tb_line_buf_pingpong_ctrl: directed bench, two DUTs (COL_WIDTH 10 and 3)
// sharing one video input, each with its own line_buf RAM model.
module tb_line_buf_pingpong_ctrl;
  logic clk;
  logic rstn;
  logic vs;
  logic de;
  logic [15:0] din;

  int n_cmp = 0;
  int n_err = 0;

  line_buf_pingpong_ctrl_if #(
    .DATA_WIDTH(16), .COL_WIDTH(10)) bif ();
  line_buf_pingpong_ctrl_if #(
    .DATA_WIDTH(16), .COL_WIDTH(3)) bif3 ();

  line_buf_pingpong_ctrl #(
    .DATA_WIDTH(16), .COL_WIDTH(10)
  ) u_dut (
    .clk(clk), .rstn(rstn), .bus(bif));

  line_buf_pingpong_ctrl #(
    .DATA_WIDTH(16), .COL_WIDTH(3)
  ) u_dut3 (
    .clk(clk), .rstn(rstn), .bus(bif3));

  assign bif.in_vs    = vs;
  assign bif.in_de    = de;
  assign bif.in_data  = din;
  assign bif3.in_vs   = vs;
  assign bif3.in_de   = de;
  assign bif3.in_data = din;

  logic [15:0] mem [0:2047];
  logic [15:0] mem3 [0:15];
  logic [15:0] rd_q, rd3_q;

  always @(posedge clk) begin
    if (bif.ram_wr_en)
      mem[bif.ram_wr_addr] <= bif.ram_wr_data;
    rd_q <= mem[bif.ram_rd_addr];
    if (bif3.ram_wr_en)
      mem3[bif3.ram_wr_addr] <= bif3.ram_wr_data;
    rd3_q <= mem3[bif3.ram_rd_addr];
  end

  assign bif.ram_rd_data  = rd_q;
  assign bif3.ram_rd_data = rd3_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] r_pre_de [16];
  logic [31:0] r_wen    [16];
  logic [31:0] r_waddr  [16];
  logic [31:0] r_raddr  [16];
  logic [31:0] r_de     [16];
  logic [31:0] r_cur    [16];
  logic [31:0] r_prev   [16];
  logic [31:0] r_vld    [16];
  logic [31:0] e_wen    [16];
  logic [31:0] e_waddr  [16];
  logic [31:0] e_ovf    [16];
  logic [31:0] e_cur    [16];
  logic [31:0] e_vld    [16];
  logic [31:0] tail_de;
  logic [31:0] acc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(
    input int row, input int col);
    return 16'h0100 + 16'(row * 16 + col);
  endfunction

  task automatic set_in(input logic v,
                        input logic d,
                        input logic [15:0] x);
    vs  = v;
    de  = d;
    din = x;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    set_in(1'b1, 1'b0, 16'h0);
    tick();
    set_in(1'b0, 1'b0, 16'h0);
    tick();
    tick();
  endtask

  task automatic line(input int row,
                      input int n,
                      input int gap);
    for (int c = 0; c < n; c++) begin
      set_in(1'b0, 1'b1, pix(row, c));
      r_pre_de[c] = 32'(bif.out_de);
      r_wen[c]    = 32'(bif.ram_wr_en);
      r_waddr[c]  = 32'(bif.ram_wr_addr);
      r_raddr[c]  = 32'(bif.ram_rd_addr);
      e_wen[c]    = 32'(bif3.ram_wr_en);
      e_waddr[c]  = 32'(bif3.ram_wr_addr);
      tick();
      r_de[c]   = 32'(bif.out_de);
      r_cur[c]  = 32'(bif.out_cur);
      r_prev[c] = 32'(bif.out_prev);
      r_vld[c]  = 32'(bif.out_prev_vld);
      e_ovf[c]  = 32'(bif3.ovf);
      e_cur[c]  = 32'(bif3.out_cur);
      e_vld[c]  = 32'(bif3.out_prev_vld);
    end
    for (int g = 0; g < gap; g++) begin
      set_in(1'b0, 1'b0, 16'h0);
      tick();
      if (g == 0)
        tail_de = 32'(bif.out_de);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    set_in(1'b0, 1'b0, 16'h0);
    tick();
    tick();
    check("rst_de", 32'(bif.out_de), 0);
    check("rst_cur", 32'(bif.out_cur), 0);
    check("rst_vld", 32'(bif.out_prev_vld), 0);
    check("rst_ovf", 32'(bif.ovf), 0);
    check("rst_wen", 32'(bif.ram_wr_en), 0);
    rstn = 1'b1;
    tick();

    // two 8-px lines
    vs_pulse();
    line(0, 8, 1);
    acc = 0;
    for (int c = 0; c < 8; c++)
      acc = acc | r_vld[c];
    check("l0_vld", acc, 0);
    line(1, 8, 1);
    check("l1_pre_de", r_pre_de[0], 0);
    check("l1_de0", r_de[0], 1);
    check("l1_cur3", r_cur[3], 32'h0113);
    check("l1_prev3", r_prev[3], 32'h0103);
    check("l1_vld3", r_vld[3], 1);
    check("l1_tail_de", tail_de, 0);

    // bank alternation, 3 lines of 4 px
    for (int r = 0; r < 3; r++) begin
      line(2 + r, 4, 1);
      check("bank_wr", r_waddr[0],
            32'((r % 2) * 1024));
      check("bank_rd", r_raddr[0],
            32'((1 - r % 2) * 1024));
      check("col3_wr", r_waddr[3],
            32'((r % 2) * 1024 + 3));
      check("col3_rd", r_raddr[3],
            32'((1 - r % 2) * 1024 + 3));
      check("bank_prev2", r_prev[2],
            32'(pix(1 + r, 2)));
    end

    // 6 px then 9 px
    line(5, 6, 1);
    line(6, 9, 1);
    for (int c = 0; c < 6; c++)
      check("long_vld_in", r_vld[c], 1);
    check("long_prev5", r_prev[5],
          32'(pix(5, 5)));
    for (int c = 6; c < 9; c++) begin
      check("long_vld_out", r_vld[c], 0);
      check("long_prev_out", r_prev[c], 0);
    end

    // overflow on the COL_WIDTH=3 instance
    vs_pulse();
    check("ovf_clr_a", 32'(bif3.ovf), 0);
    line(7, 10, 1);
    acc = 0;
    for (int c = 0; c < 10; c++)
      acc = acc + e_wen[c];
    check("ovf_nwr", acc, 8);
    check("ovf_addr7", e_waddr[7], 7);
    check("ovf_at8", e_ovf[7], 0);
    check("ovf_at9", e_ovf[8], 1);
    check("ovf_cur9", e_cur[9], 32'(pix(7, 9)));
    check("ovf_vld9", e_vld[9], 0);
    check("ovf_wide", 32'(bif.ovf), 0);
    vs_pulse();
    check("ovf_clr_b", 32'(bif3.ovf), 0);

    // vs rise mid-line with de held high
    line(8, 4, 1);
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, 1'b1, pix(9, c));
      tick();
    end
    set_in(1'b1, 1'b1, pix(9, 5));
    check("vs_wen", 32'(bif.ram_wr_en), 0);
    tick();
    for (int c = 6; c < 8; c++) begin
      set_in(1'b1, 1'b1, pix(9, c));
      check("vs_hold_wen",
            32'(bif.ram_wr_en), 0);
      tick();
      check("vs_hold_de", 32'(bif.out_de), 0);
    end
    set_in(1'b0, 1'b0, 16'h0);
    tick();
    line(10, 4, 1);
    check("vs_bank", r_waddr[0], 0);
    check("vs_wen_new", r_wen[0], 1);
    acc = 0;
    for (int c = 0; c < 4; c++)
      acc = acc | r_vld[c];
    check("vs_vld", acc, 0);

    // reset mid-line
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'b1, pix(11, c));
      tick();
    end
    rstn = 1'b0;
    set_in(1'b0, 1'b1, pix(11, 3));
    check("mrst_wen", 32'(bif.ram_wr_en), 0);
    tick();
    rstn = 1'b1;
    check("mrst_de", 32'(bif.out_de), 0);
    check("mrst_cur", 32'(bif.out_cur), 0);
    for (int c = 4; c < 7; c++) begin
      set_in(1'b0, 1'b1, pix(11, c));
      check("mrst_wen_after",
            32'(bif.ram_wr_en), 0);
      tick();
      check("mrst_de_after",
            32'(bif.out_de), 0);
    end
    set_in(1'b0, 1'b0, 16'h0);
    tick();
    vs_pulse();
    line(12, 5, 1);
    check("mrst_wen_vs", r_wen[0], 1);
    line(13, 5, 1);
    check("st_vld4", r_vld[4], 1);
    check("st_prev4", r_prev[4],
          32'(pix(12, 4)));
    line(14, 5, 1);
`ifdef LINE_BUF_PINGPONG_CTRL_STATS_EN
    check("st_cnt", 32'(bif.line_cnt), 3);
    check("st_len", 32'(bif.line_len), 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
